// File: rtl/alu_pkg.sv
// Shared op codes and controller state encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done is high during the final iteration so the product is in p the cycle after.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      a_d    = A;
      b_d    = B;
      p_d    = '0;
      cnt_d  = CW'(WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (b_q[0]) p_d = p_q + a_q;
      a_d = a_q << 1;
      b_d = b_q >> 1;
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);
  assign p    = p_q;

endmodule

// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus an iterative multiply.
// state  | meaning
// S_IDLE | accepting operands; single-cycle results registered on accept
// S_MUL  | multiplier iterating, input port closed
// S_DONE | product ready, written to result registers this cycle
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  state_t state_q, state_d;

  logic [WIDTH-1:0] y_q, y_d;
  logic zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, err_q, err_d;
  logic out_valid_q, out_valid_d;

  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_p;

  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c, alu_v, alu_e;
  logic             accept;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .A     (A),
    .B     (B),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  assign in_ready = (state_q == S_IDLE) & ~mul_busy & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  assign sum   = {1'b0, A} + {1'b0, B};
  // Subtract as A + ~B + 1 so the carry out reads directly as no-borrow.
  assign diff  = {1'b0, A} + {1'b0, ~B} + (WIDTH + 1)'(1);
  assign shamt = B[SHW-1:0];

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = 1'b0;
    case (op)
      OP_AND:  alu_y = A & B;
      OP_OR:   alu_y = A | B;
      OP_NOR:  alu_y = ~(A | B);
      OP_ADD: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  alu_y = A << shamt;
      OP_SRL:  alu_y = A >> shamt;
      OP_SRA:  alu_y = $unsigned($signed(A) >>> shamt);
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (A < B)};
      default: alu_e = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mul_start   = 1'b0;
    y_d         = y_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    out_valid_d = out_valid_q & ~out_ready;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else begin
            y_d         = alu_y;
            zero_d      = (alu_y == '0);
            carry_d     = alu_c;
            ovf_d       = alu_v;
            err_d       = alu_e;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: if (mul_done) state_d = S_DONE;
      S_DONE: begin
        // The previous result was consumed when the multiply was accepted.
        y_d         = mul_p;
        zero_d      = (mul_p == '0);
        carry_d     = 1'b0;
        ovf_d       = 1'b0;
        err_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      y_q         <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule
